// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer (IDLE -> REQ -> DONE loop).
// Optional misaligned-target trap enabled by defining MISALIGN_CHECK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pc_fetch_unit #(
    parameter int                WIDTH    = `DATA_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
`ifdef MISALIGN_CHECK_EN
        , S_ERR = 2'd3
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_q, pc_nxt;
    logic [WIDTH-1:0] instr_q, instr_nxt;
    logic             req_q, vld_q;

`ifdef MISALIGN_CHECK_EN
    logic err_q, err_nxt;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
`ifdef MISALIGN_CHECK_EN
        err_nxt   = err_q;
`endif
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (imem_ready) begin
                    instr_nxt = imem_rdata;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!stall) begin
`ifdef MISALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        pc_nxt    = next_pc;
                        state_nxt = S_REQ;
                    end
`else
                    // Low address bits are forced clear rather than trapped.
                    pc_nxt    = next_pc & ~WIDTH'(3);
                    state_nxt = S_REQ;
`endif
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            // Handshake outputs are registered copies of the next-state decode.
            req_q   <= (state_nxt == S_REQ);
            vld_q   <= (state_nxt == S_DONE);
`ifdef MISALIGN_CHECK_EN
            err_q   <= err_nxt;
`endif
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + WIDTH'(4);
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
`ifdef MISALIGN_CHECK_EN
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps

module tb_pc_fetch_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] next_pc;
  logic         stall;
  logic         imem_ready;
  logic [W-1:0] imem_rdata;
  logic [W-1:0] pc, pc_plus4, imem_addr, instr;
  logic         imem_req, instr_valid, misalign_err;

  logic         use_p4;
  logic [W-1:0] np_val;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mem(input logic [W-1:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign next_pc    = use_p4 ? pc_plus4 : np_val;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1; use_p4 = 1'b1; np_val = '0;
    tick(); tick();
    total++; if (pc !== 32'h0) begin bad++; $error("FAIL rst_pc observed=%0h expected=%0h", pc, 32'h0); end
    total++; if (imem_req !== 1'b0) begin bad++; $error("FAIL rst_req observed=%0h expected=%0h", imem_req, 1'b0); end
    total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL rst_vld observed=%0h expected=%0h", instr_valid, 1'b0); end
    total++; if (instr !== 32'h0) begin bad++; $error("FAIL rst_instr observed=%0h expected=%0h", instr, 32'h0); end
    total++; if (misalign_err !== 1'b0) begin bad++; $error("FAIL rst_err observed=%0h expected=%0h", misalign_err, 1'b0); end

    // sequential fetch 0,4,8
    rst_n = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $error("FAIL t1_req0 observed=%0h expected=%0h", imem_req, 1'b1); end
    total++; if (imem_addr !== 32'h0) begin bad++; $error("FAIL t1_addr0 observed=%0h expected=%0h", imem_addr, 32'h0); end
    total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL t1_vld0 observed=%0h expected=%0h", instr_valid, 1'b0); end
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $error("FAIL t1_vld1 observed=%0h expected=%0h", instr_valid, 1'b1); end
    total++; if (instr !== mem(32'h0)) begin bad++; $error("FAIL t1_instr0 observed=%0h expected=%0h", instr, mem(32'h0)); end
    total++; if (imem_req !== 1'b0) begin bad++; $error("FAIL t1_reqlow observed=%0h expected=%0h", imem_req, 1'b0); end
    tick();
    total++; if (pc !== 32'h4) begin bad++; $error("FAIL t1_pc4 observed=%0h expected=%0h", pc, 32'h4); end
    total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL t1_vld2 observed=%0h expected=%0h", instr_valid, 1'b0); end
    tick();
    total++; if (instr !== mem(32'h4)) begin bad++; $error("FAIL t1_instr4 observed=%0h expected=%0h", instr, mem(32'h4)); end
    tick();
    total++; if (pc !== 32'h8) begin bad++; $error("FAIL t1_pc8 observed=%0h expected=%0h", pc, 32'h8); end

    // wait states at pc=100
    tick();
    use_p4 = 1'b0; np_val = 32'd100;
    tick();
    imem_ready = 1'b0;
    total++; if (imem_req !== 1'b1) begin bad++; $error("FAIL t2_req_a observed=%0h expected=%0h", imem_req, 1'b1); end
    total++; if (imem_addr !== 32'd100) begin bad++; $error("FAIL t2_addr_a observed=%0h expected=%0h", imem_addr, 32'd100); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_req !== 1'b1) begin bad++; $error("FAIL t2_req_w observed=%0h expected=%0h", imem_req, 1'b1); end
      total++; if (imem_addr !== 32'd100) begin bad++; $error("FAIL t2_addr_w observed=%0h expected=%0h", imem_addr, 32'd100); end
      total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL t2_vld_w observed=%0h expected=%0h", instr_valid, 1'b0); end
    end
    imem_ready = 1'b1;
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $error("FAIL t2_vld observed=%0h expected=%0h", instr_valid, 1'b1); end
    total++; if (instr !== mem(32'd100)) begin bad++; $error("FAIL t2_instr observed=%0h expected=%0h", instr, mem(32'd100)); end

    // stall in DONE
    stall = 1'b1; np_val = 32'd10000; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 32'd100) begin bad++; $error("FAIL t3_pc_hold observed=%0h expected=%0h", pc, 32'd100); end
      total++; if (instr !== mem(32'd100)) begin bad++; $error("FAIL t3_instr_hold observed=%0h expected=%0h", instr, mem(32'd100)); end
      total++; if (instr_valid !== 1'b1) begin bad++; $error("FAIL t3_vld_hold observed=%0h expected=%0h", instr_valid, 1'b1); end
    end
    stall = 1'b0; imem_ready = 1'b1;
    tick();
    total++; if (pc !== 32'd10000) begin bad++; $error("FAIL t3_pc_new observed=%0h expected=%0h", pc, 32'd10000); end
    total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL t3_vld_drop observed=%0h expected=%0h", instr_valid, 1'b0); end

    // wrap at top of address space
    tick();
    np_val = 32'hFFFF_FFFC;
    tick();
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $error("FAIL t4_pc_top observed=%0h expected=%0h", pc, 32'hFFFF_FFFC); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $error("FAIL t4_p4_wrap observed=%0h expected=%0h", pc_plus4, 32'h0); end
    tick();
    use_p4 = 1'b1;
    tick();
    total++; if (pc !== 32'h0) begin bad++; $error("FAIL t4_pc_wrap observed=%0h expected=%0h", pc, 32'h0); end

    // reset while requesting at pc=200
    tick();
    use_p4 = 1'b0; np_val = 32'd200;
    tick();
    total++; if (pc !== 32'd200) begin bad++; $error("FAIL t5_pc200 observed=%0h expected=%0h", pc, 32'd200); end
    total++; if (imem_req !== 1'b1) begin bad++; $error("FAIL t5_req observed=%0h expected=%0h", imem_req, 1'b1); end
    rst_n = 1'b0;
    tick();
    total++; if (pc !== 32'h0) begin bad++; $error("FAIL t5_rst_pc observed=%0h expected=%0h", pc, 32'h0); end
    total++; if (imem_req !== 1'b0) begin bad++; $error("FAIL t5_rst_req observed=%0h expected=%0h", imem_req, 1'b0); end
    total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL t5_rst_vld observed=%0h expected=%0h", instr_valid, 1'b0); end
    rst_n = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $error("FAIL t5_req_back observed=%0h expected=%0h", imem_req, 1'b1); end

    // misaligned target
    tick();
    np_val = 32'd100;
    tick();
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $error("FAIL t6_done observed=%0h expected=%0h", instr_valid, 1'b1); end
    np_val = 32'd102;
    tick();
    total++; if (pc !== 32'd100) begin bad++; $error("FAIL t6_pc observed=%0h expected=%0h", pc, 32'd100); end
    total++; if (instr_valid !== 1'b0) begin bad++; $error("FAIL t6_vld observed=%0h expected=%0h", instr_valid, 1'b0); end
`ifdef MISALIGN_CHECK_EN
    total++; if (misalign_err !== 1'b1) begin bad++; $error("FAIL t6_err observed=%0h expected=%0h", misalign_err, 1'b1); end
    total++; if (imem_req !== 1'b0) begin bad++; $error("FAIL t6_req observed=%0h expected=%0h", imem_req, 1'b0); end
    tick(); tick();
    total++; if (misalign_err !== 1'b1) begin bad++; $error("FAIL t6_err_hold observed=%0h expected=%0h", misalign_err, 1'b1); end
    total++; if (imem_req !== 1'b0) begin bad++; $error("FAIL t6_req_hold observed=%0h expected=%0h", imem_req, 1'b0); end
    total++; if (pc !== 32'd100) begin bad++; $error("FAIL t6_pc_hold observed=%0h expected=%0h", pc, 32'd100); end
    rst_n = 1'b0;
    tick();
    total++; if (misalign_err !== 1'b0) begin bad++; $error("FAIL t6_err_clr observed=%0h expected=%0h", misalign_err, 1'b0); end
    rst_n = 1'b1;
`else
    total++; if (misalign_err !== 1'b0) begin bad++; $error("FAIL t6_err observed=%0h expected=%0h", misalign_err, 1'b0); end
    total++; if (imem_req !== 1'b1) begin bad++; $error("FAIL t6_req observed=%0h expected=%0h", imem_req, 1'b1); end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
